// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the 5-stage RV64 pipeline. It sits downstream
// of Reg_file and:
//   - captures the decoded fields and the Rs1_data/Rs2_data read ports,
//   - resolves RAW hazards by forwarding from EX/MEM/WB,
//   - detects load-use hazards and stalls the front end,
//   - inserts bubbles on stall or branch flush,
//   - counts stall cycles in a saturating counter.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   id_*                        decode slot: valid, rs1/rs2 index + used flags,
//                               rd index + write enable, load flag, ALU op,
//                               immediate, PC
//   rs1_data, rs2_data          Reg_file read data for id_rs1_addr/id_rs2_addr
//   ex_result                   ALU output of the instruction now in EX
//   mem_rd_addr/wen, mem_result MEM-stage destination and value
//   wb_rd_addr/wen, wb_data     WB-stage destination and value
//   flush                       kill the decode slot (branch taken/mispredict)
//   stall                       combinational: hold PC and IF/ID this cycle
//   ex_*                        registered EX-slot contents (operands forwarded)
//   stall_count                 stall cycles since reset, saturates at all-ones
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rd_wen,
  input  logic             id_is_load,
  input  logic [3:0]       id_alu_ctrl,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_rd_wen,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_rd_wen,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_rd_wen,
  output logic             ex_is_load,
  output logic [3:0]       ex_alu_ctrl,
  output logic [CNT_W-1:0] stall_count
);

  // EX-slot registers
  logic             r_valid;
  logic [XLEN-1:0]  r_rs1_val;
  logic [XLEN-1:0]  r_rs2_val;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_pc;
  logic [4:0]       r_rd_addr;
  logic             r_rd_wen;
  logic             r_is_load;
  logic [3:0]       r_alu_ctrl;
  logic [CNT_W-1:0] r_stall_count;

  logic             w_hz;
  logic             w_stall;
  logic [XLEN-1:0]  w_rs1_fwd;
  logic [XLEN-1:0]  w_rs2_fwd;

  // Operand select, first match wins. x0 reads as zero regardless of what
  // any stage claims to write to it. A load in EX has no result yet, so it
  // is skipped here; the hazard logic stalls instead.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_v,
    input logic            ex_w,
    input logic            ex_ld,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_res,
    input logic            m_w,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_res,
    input logic            w_w,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_dat
  );
    logic [XLEN-1:0] v;
    v = rf_data;
    if (addr == 5'd0)                                  v = '0;
    else if (ex_v && ex_w && !ex_ld && ex_rd == addr)  v = ex_res;
    else if (m_w && m_rd == addr)                      v = m_res;
    else if (w_w && w_rd == addr)                      v = w_dat;
    return v;
  endfunction

  always_comb begin
    w_rs1_fwd = fwd_sel(id_rs1_addr, rs1_data, r_valid, r_rd_wen, r_is_load,
                        r_rd_addr, ex_result, mem_rd_wen, mem_rd_addr,
                        mem_result, wb_rd_wen, wb_rd_addr, wb_data);
    w_rs2_fwd = fwd_sel(id_rs2_addr, rs2_data, r_valid, r_rd_wen, r_is_load,
                        r_rd_addr, ex_result, mem_rd_wen, mem_rd_addr,
                        mem_result, wb_rd_wen, wb_rd_addr, wb_data);
  end

  // Load-use: the consumer needs a value the load in EX has not produced yet.
  always_comb begin
    w_hz = id_valid && r_valid && r_is_load && r_rd_wen && (r_rd_addr != 5'd0)
           && ((id_rs1_used && id_rs1_addr == r_rd_addr) ||
               (id_rs2_used && id_rs2_addr == r_rd_addr));
    // A flush kills the consumer, so there is nothing to wait for.
    w_stall = w_hz && !flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_rs1_val     <= '0;
      r_rs2_val     <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_rd_addr     <= '0;
      r_rd_wen      <= 1'b0;
      r_is_load     <= 1'b0;
      r_alu_ctrl    <= '0;
      r_stall_count <= '0;
    end else if (flush || w_stall || !id_valid) begin
      // Bubble: every EX field cleared, not just the control bits.
      r_valid    <= 1'b0;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_rd_addr  <= '0;
      r_rd_wen   <= 1'b0;
      r_is_load  <= 1'b0;
      r_alu_ctrl <= '0;
      if (w_stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
    end else begin
      r_valid    <= 1'b1;
      r_rs1_val  <= w_rs1_fwd;
      r_rs2_val  <= w_rs2_fwd;
      r_imm      <= id_imm;
      r_pc       <= id_pc;
      r_rd_addr  <= id_rd_addr;
      r_rd_wen   <= id_rd_wen;
      r_is_load  <= id_is_load;
      r_alu_ctrl <= id_alu_ctrl;
    end
  end

  assign stall       = w_stall;
  assign ex_valid    = r_valid;
  assign ex_rs1_val  = r_rs1_val;
  assign ex_rs2_val  = r_rs2_val;
  assign ex_imm      = r_imm;
  assign ex_pc       = r_pc;
  assign ex_rd_addr  = r_rd_addr;
  assign ex_rd_wen   = r_rd_wen;
  assign ex_is_load  = r_is_load;
  assign ex_alu_ctrl = r_alu_ctrl;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rd_wen = 1'b0, id_is_load = 1'b0;
  logic [3:0]  id_alu_ctrl = '0;
  logic [63:0] id_imm = '0, id_pc = '0, rs1_data = '0, rs2_data = '0;
  logic [63:0] ex_result = '0, mem_result = '0, wb_data = '0;
  logic [4:0]  mem_rd_addr = '0, wb_rd_addr = '0;
  logic        mem_rd_wen = 1'b0, wb_rd_wen = 1'b0, flush = 1'b0;

  logic        stall, ex_valid, ex_rd_wen, ex_is_load;
  logic [63:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
  logic [4:0]  ex_rd_addr;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] stall_count;

  // Second instance with a 2-bit counter, fed identical stimulus, to reach saturation quickly
  logic        s_stall, s_ex_valid, s_ex_rd_wen, s_ex_is_load;
  logic [63:0] s_ex_rs1_val, s_ex_rs2_val, s_ex_imm, s_ex_pc;
  logic [4:0]  s_ex_rd_addr;
  logic [3:0]  s_ex_alu_ctrl;
  logic [1:0]  s_stall_count;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
    .id_alu_ctrl(id_alu_ctrl), .id_imm(id_imm), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wen(mem_rd_wen), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wen(wb_rd_wen), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
    .ex_alu_ctrl(ex_alu_ctrl), .stall_count(stall_count)
  );

  id_ex_stage #(.XLEN(64), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
    .id_alu_ctrl(id_alu_ctrl), .id_imm(id_imm), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wen(mem_rd_wen), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wen(wb_rd_wen), .wb_data(wb_data),
    .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid),
    .ex_rs1_val(s_ex_rs1_val), .ex_rs2_val(s_ex_rs2_val), .ex_imm(s_ex_imm), .ex_pc(s_ex_pc),
    .ex_rd_addr(s_ex_rd_addr), .ex_rd_wen(s_ex_rd_wen), .ex_is_load(s_ex_is_load),
    .ex_alu_ctrl(s_ex_alu_ctrl), .stall_count(s_stall_count)
  );

  typedef struct {
    logic        stall;
    logic        valid;
    logic [63:0] rs1, rs2, imm, pc;
    logic [4:0]  rd;
    logic        wen, ld;
    logic [3:0]  alu;
    logic [31:0] cnt;
    logic [1:0]  cnts;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input int unsigned cyc,
                     input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL c%0d.%s: got %h expected %h", cyc, name, act, exp);
    end
  endtask

  // Monitor: stall is sampled mid-cycle (before the edge it affects), the
  // registered outputs just after that edge; each edge consumes one entry.
  initial begin : monitor
    logic st_s;
    exp_t e;
    int unsigned cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      #3 st_s = stall;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        cyc++;
        chk("stall",       cyc, {63'd0, st_s},           {63'd0, e.stall});
        chk("ex_valid",    cyc, {63'd0, ex_valid},       {63'd0, e.valid});
        chk("ex_rs1_val",  cyc, ex_rs1_val,              e.rs1);
        chk("ex_rs2_val",  cyc, ex_rs2_val,              e.rs2);
        chk("ex_imm",      cyc, ex_imm,                  e.imm);
        chk("ex_pc",       cyc, ex_pc,                   e.pc);
        chk("ex_rd_addr",  cyc, {59'd0, ex_rd_addr},     {59'd0, e.rd});
        chk("ex_rd_wen",   cyc, {63'd0, ex_rd_wen},      {63'd0, e.wen});
        chk("ex_is_load",  cyc, {63'd0, ex_is_load},     {63'd0, e.ld});
        chk("ex_alu_ctrl", cyc, {60'd0, ex_alu_ctrl},    {60'd0, e.alu});
        chk("stall_count", cyc, {32'd0, stall_count},    {32'd0, e.cnt});
        chk("stall_count_small", cyc, {62'd0, s_stall_count}, {62'd0, e.cnts});
      end
    end
  end

  task automatic set_id(input logic v, input logic [4:0] a1, a2, input logic u1, u2,
                        input logic [4:0] rd, input logic w, ld, input logic [3:0] alu,
                        input logic [63:0] imm, pc, d1, d2);
    id_valid = v; id_rs1_addr = a1; id_rs2_addr = a2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd_addr = rd; id_rd_wen = w; id_is_load = ld; id_alu_ctrl = alu;
    id_imm = imm; id_pc = pc; rs1_data = d1; rs2_data = d2;
  endtask

  task automatic set_fwd(input logic [63:0] exr, input logic [4:0] mrd, input logic mw,
                         input logic [63:0] mres, input logic [4:0] wrd, input logic ww,
                         input logic [63:0] wd);
    ex_result = exr; mem_rd_addr = mrd; mem_rd_wen = mw; mem_result = mres;
    wb_rd_addr = wrd; wb_rd_wen = ww; wb_data = wd;
  endtask

  task automatic push(input logic st, v, input logic [63:0] a, b, imm, pc,
                      input logic [4:0] rd, input logic w, ld, input logic [3:0] alu,
                      input logic [31:0] cnt, input logic [1:0] cs);
    exp_t e;
    e.stall = st; e.valid = v; e.rs1 = a; e.rs2 = b; e.imm = imm; e.pc = pc;
    e.rd = rd; e.wen = w; e.ld = ld; e.alu = alu; e.cnt = cnt; e.cnts = cs;
    q.push_back(e);
  endtask

  task automatic push_bubble(input logic st, input logic [31:0] cnt, input logic [1:0] cs);
    push(st, 1'b0, '0, '0, '0, '0, 5'd0, 1'b0, 1'b0, 4'd0, cnt, cs);
  endtask

  initial begin : driver
    @(negedge clk);
    // Reset for two cycles with garbage on the inputs
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1;
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 4'hF,
             64'hDEAD, 64'hBEEF, 64'h1111, 64'h2222);
      set_fwd(64'h3333, 5'd7, 1'b1, 64'h4444, 5'd7, 1'b1, 64'h5555);
      push_bubble(1'b0, 32'd0, 2'd0);
      @(negedge clk);
    end
    reset = 1'b0;

    // ADD x5, x20, x21 with no hazards
    set_id(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 4'd0,
           64'h10, 64'h1000, 64'h456701023D2, 64'h12005C2);
    set_fwd('0, 5'd0, 1'b0, '0, 5'd0, 1'b0, '0);
    push(1'b0, 1'b1, 64'h456701023D2, 64'h12005C2, 64'h10, 64'h1000, 5'd5, 1'b1, 1'b0, 4'd0, 32'd0, 2'd0);
    @(negedge clk);

    // Producer of x10 (non-load)
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 4'd3,
           64'h0, 64'h1004, 64'h11, 64'h22);
    push(1'b0, 1'b1, 64'h11, 64'h22, 64'h0, 64'h1004, 5'd10, 1'b1, 1'b0, 4'd3, 32'd0, 2'd0);
    @(negedge clk);

    // LD x7 reading x10 (EX beats MEM) and x3 (from WB)
    set_id(1'b1, 5'd10, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 4'd0,
           64'h8, 64'h1008, 64'hAAAA, 64'h33);
    set_fwd(64'hFFF, 5'd10, 1'b1, 64'h1, 5'd3, 1'b1, 64'h7777);
    push(1'b0, 1'b1, 64'hFFF, 64'h7777, 64'h8, 64'h1008, 5'd7, 1'b1, 1'b1, 4'd0, 32'd0, 2'd0);
    @(negedge clk);

    // Consumer of x7 right behind the load: stall, bubble
    set_id(1'b1, 5'd4, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 4'd1,
           64'h0, 64'h100C, 64'h44, 64'h99);
    set_fwd(64'h0, 5'd10, 1'b1, 64'h5, 5'd0, 1'b0, '0);
    push_bubble(1'b1, 32'd1, 2'd1);
    @(negedge clk);

    // Same consumer again; load now in MEM
    set_fwd(64'h0, 5'd7, 1'b1, 64'hDEADBEEF, 5'd10, 1'b1, 64'h1);
    push(1'b0, 1'b1, 64'h44, 64'hDEADBEEF, 64'h0, 64'h100C, 5'd8, 1'b1, 1'b0, 4'd1, 32'd1, 2'd1);
    @(negedge clk);

    // LD x9 (rs2 = x0, unused)
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 4'd0,
           64'h20, 64'h1010, 64'h100, 64'h0);
    set_fwd('0, 5'd0, 1'b0, '0, 5'd0, 1'b0, '0);
    push(1'b0, 1'b1, 64'h100, 64'h0, 64'h20, 64'h1010, 5'd9, 1'b1, 1'b1, 4'd0, 32'd1, 2'd1);
    @(negedge clk);

    // Load-use hazard coinciding with flush: no stall, bubble, count unchanged
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 4'd2,
           64'h0, 64'h1014, 64'h90, 64'h0);
    flush = 1'b1;
    push_bubble(1'b0, 32'd1, 2'd1);
    @(negedge clk);
    flush = 1'b0;

    // Instruction that "writes" x0
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 4'd2,
           64'h0, 64'h1018, 64'h2, 64'h3);
    push(1'b0, 1'b1, 64'h2, 64'h3, 64'h0, 64'h1018, 5'd0, 1'b1, 1'b0, 4'd2, 32'd1, 2'd1);
    @(negedge clk);

    // Reads x0 while EX and MEM both claim x0: operands must be 0. Itself a load to x0.
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 4'd0,
           64'h4, 64'h101C, 64'hBAD, 64'hBAD);
    set_fwd(64'h1234, 5'd0, 1'b1, 64'h55, 5'd0, 1'b0, '0);
    push(1'b0, 1'b1, 64'h0, 64'h0, 64'h4, 64'h101C, 5'd0, 1'b1, 1'b1, 4'd0, 32'd1, 2'd1);
    @(negedge clk);

    // Reading x0 behind a load to x0 is not a hazard
    set_id(1'b1, 5'd0, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 4'd0,
           64'h0, 64'h1020, 64'hBAD, 64'h5);
    set_fwd('0, 5'd0, 1'b0, '0, 5'd0, 1'b0, '0);
    push(1'b0, 1'b1, 64'h0, 64'h5, 64'h0, 64'h1020, 5'd1, 1'b1, 1'b0, 4'd0, 32'd1, 2'd1);
    @(negedge clk);

    // Repeated load-use pairs: small counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 4'd0,
             64'h0, 64'h1030, 64'h10, 64'h0);
      push(1'b0, 1'b1, 64'h10, 64'h0, 64'h0, 64'h1030, 5'd6, 1'b1, 1'b1, 4'd0,
           32'(1 + i), (i == 0) ? 2'd1 : ((i == 1) ? 2'd2 : 2'd3));
      @(negedge clk);
      set_id(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 4'd5,
             64'h0, 64'h1034, 64'h66, 64'h66);
      push_bubble(1'b1, 32'(2 + i), (i == 0) ? 2'd2 : 2'd3);
      @(negedge clk);
    end

    // Reset during a stall: reset wins, next cycle has no stall
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 4'd0,
           64'h0, 64'h1030, 64'h10, 64'h0);
    push(1'b0, 1'b1, 64'h10, 64'h0, 64'h0, 64'h1030, 5'd6, 1'b1, 1'b1, 4'd0, 32'd4, 2'd3);
    @(negedge clk);
    set_id(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 4'd5,
           64'h0, 64'h1034, 64'h66, 64'h66);
    reset = 1'b1;
    push_bubble(1'b1, 32'd0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    push(1'b0, 1'b1, 64'h66, 64'h66, 64'h0, 64'h1034, 5'd2, 1'b1, 1'b0, 4'd5, 32'd0, 2'd0);
    @(negedge clk);

    // Empty decode slot -> bubble
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 4'd1,
           64'h9, 64'h1038, 64'h0, 64'h0);
    push_bubble(1'b0, 32'd0, 2'd0);
    @(negedge clk);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
